// File: rtl/max7219_pkg.sv
// ============================================================================
// max7219_pkg: MAX7219 register map, frame width and transmitter state type
// Rev 1.0
// ============================================================================
`default_nettype none

package max7219_pkg;

    localparam int FRAME_BITS = 16;

    localparam logic [3:0] NOOP         = 4'h0;
    localparam logic [3:0] DIGIT0       = 4'h1;
    localparam logic [3:0] DIGIT1       = 4'h2;
    localparam logic [3:0] DIGIT2       = 4'h3;
    localparam logic [3:0] DIGIT3       = 4'h4;
    localparam logic [3:0] DIGIT4       = 4'h5;
    localparam logic [3:0] DIGIT5       = 4'h6;
    localparam logic [3:0] DIGIT6       = 4'h7;
    localparam logic [3:0] DIGIT7       = 4'h8;
    localparam logic [3:0] DECODE_MODE  = 4'h9;
    localparam logic [3:0] INTENSITY    = 4'hA;
    localparam logic [3:0] SCAN_LIMIT   = 4'hB;
    localparam logic [3:0] SHUTDOWN     = 4'hC;
    localparam logic [3:0] DISPLAY_TEST = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2,
        ST_GAP   = 2'd3
    } tx_state_t;

    function automatic logic [FRAME_BITS-1:0] make_frame(input logic [3:0] addr,
                                                         input logic [7:0] value);
        return {4'h0, addr, value};
    endfunction

endpackage

`default_nettype wire

// File: rtl/max7219_sclk_div.sv
// ============================================================================
// max7219_sclk_div: half-period strobe generator for the MAX7219 serial clock
// Rev 1.0
// ============================================================================
`default_nettype none

module max7219_sclk_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic strobe,
    output logic pre_strobe
);

    localparam int              CNT_W = $clog2(CLK_DIV + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // strobe marks the last clk cycle of each half period
    assign strobe = en && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en || strobe) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // pre_strobe: the following cycle will strobe if the divider stays enabled
    if (CLK_DIV == 1) begin : g_single
        assign pre_strobe = en;
    end else begin : g_multi
        localparam logic [CNT_W-1:0] PRE = CNT_W'(CLK_DIV - 2);
        assign pre_strobe = en && (cnt == PRE);
    end

endmodule

`default_nettype wire

// File: rtl/max7219_serial_tx.sv
// ============================================================================
// max7219_serial_tx: shifts a 16-bit register-write frame out MSB first on
// DIN/CLK, then pulses LOAD so the MAX7219 latches it.  Rev 1.0
// ============================================================================
`default_nettype none

module max7219_serial_tx
    import max7219_pkg::*;
#(
    parameter int CLK_DIV   = 2,
    parameter int LOAD_HOLD = 2
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [15:0] i_data,
    input  logic        i_valid,
    output logic        o_ready,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_serial_dout,
    output logic        o_serial_clk,
    output logic        o_serial_load
);

    localparam int                HOLD_W    = $clog2(LOAD_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LOAD_HOLD - 1);
    localparam logic [3:0]        BIT_FIRST = 4'(FRAME_BITS - 1);

    tx_state_t             state, state_n;
    logic [FRAME_BITS-1:0] shreg, shreg_n;
    logic [3:0]            bit_cnt, bit_cnt_n;
    logic                  phase_hi, phase_hi_n;
    logic [HOLD_W-1:0]     hold_cnt, hold_cnt_n;
    logic                  sclk, sclk_n;
    logic                  load, load_n;
    logic                  done, done_n;
    logic                  ready, ready_n;
    logic                  busy, busy_n;

    logic                  div_en;
    logic                  strobe;
    logic                  pre_strobe;

    assign div_en = (state != ST_IDLE);

    max7219_sclk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_div (
        .clk        (i_clk),
        .rst_n      (i_reset_n),
        .en         (div_en),
        .strobe     (strobe),
        .pre_strobe (pre_strobe)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            phase_hi <= 1'b0;
            hold_cnt <= '0;
            sclk     <= 1'b0;
            load     <= 1'b0;
            done     <= 1'b0;
            ready    <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            bit_cnt  <= bit_cnt_n;
            phase_hi <= phase_hi_n;
            hold_cnt <= hold_cnt_n;
            sclk     <= sclk_n;
            load     <= load_n;
            done     <= done_n;
            ready    <= ready_n;
            busy     <= busy_n;
        end
    end

    always_comb begin
        state_n    = state;
        shreg_n    = shreg;
        bit_cnt_n  = bit_cnt;
        phase_hi_n = phase_hi;
        hold_cnt_n = hold_cnt;
        sclk_n     = sclk;
        load_n     = load;
        done_n     = 1'b0;
        ready_n    = ready;
        busy_n     = busy;

        case (state)
            ST_IDLE: begin
                if (i_valid) begin
                    state_n    = ST_SHIFT;
                    shreg_n    = i_data;
                    bit_cnt_n  = BIT_FIRST;
                    phase_hi_n = 1'b0;
                    sclk_n     = 1'b0;
                    ready_n    = 1'b0;
                    busy_n     = 1'b1;
                end
            end

            ST_SHIFT: begin
                if (strobe) begin
                    if (!phase_hi) begin
                        phase_hi_n = 1'b1;
                        sclk_n     = 1'b1;
                    end else begin
                        phase_hi_n = 1'b0;
                        sclk_n     = 1'b0;
                        // bit 0 stays on DIN through LATCH, so no final shift
                        if (bit_cnt == 4'd0) begin
                            state_n    = ST_LATCH;
                            load_n     = 1'b1;
                            hold_cnt_n = '0;
                        end else begin
                            bit_cnt_n = bit_cnt - 4'd1;
                            shreg_n   = {shreg[FRAME_BITS-2:0], 1'b0};
                        end
                    end
                end
            end

            ST_LATCH: begin
                if (strobe) begin
                    if (hold_cnt == HOLD_LAST) begin
                        state_n = ST_GAP;
                        load_n  = 1'b0;
                        done_n  = pre_strobe;
                    end else begin
                        hold_cnt_n = hold_cnt + 1'b1;
                    end
                end
            end

            ST_GAP: begin
                if (strobe) begin
                    state_n = ST_IDLE;
                    ready_n = 1'b1;
                    busy_n  = 1'b0;
                end else begin
                    done_n = pre_strobe;
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign o_ready       = ready;
    assign o_busy        = busy;
    assign o_done        = done;
    assign o_serial_dout = shreg[FRAME_BITS-1];
    assign o_serial_clk  = sclk;
    assign o_serial_load = load;

endmodule

`default_nettype wire
